// File: rtl/stack_mem_pkg.sv
// Shared encodings for the memory-stage stack unit: control-bundle field positions,
// address/data selector codes, PC pop markers and sticky error bit positions.
package stack_mem_pkg;
   localparam int MEM_RD      = 6;
   localparam int MEM_WR      = 5;
   localparam int MEM_ASEL_HI = 4;
   localparam int MEM_ASEL_LO = 3;
   localparam int MEM_DSEL_HI = 2;
   localparam int MEM_DSEL_LO = 0;

   localparam int WB_SP_WR    = 5;
   localparam int WB_FLAGS    = 4;
   localparam int WB_SEL      = 3;
   localparam int WB_POP_HI   = 2;
   localparam int WB_POP_LO   = 1;
   localparam int WB_REGWRITE = 0;

   typedef enum logic [1:0] {
      ADDR_SEL_EA0  = 2'b00,
      ADDR_SEL_EA1  = 2'b01,
      ADDR_SEL_POP  = 2'b10,
      ADDR_SEL_PUSH = 2'b11
   } addr_sel_e;

   typedef enum logic [2:0] {
      DATA_SEL_REG0   = 3'b000,
      DATA_SEL_REG1   = 3'b001,
      DATA_SEL_FLAGS  = 3'b010,
      DATA_SEL_PCI_LO = 3'b011,
      DATA_SEL_PCI_HI = 3'b100,
      DATA_SEL_PCN_LO = 3'b101,
      DATA_SEL_PCN_HI = 3'b110,
      DATA_SEL_REG7   = 3'b111
   } data_sel_e;

   localparam logic [1:0] POP_HI = 2'b10;
   localparam logic [1:0] POP_LO = 2'b11;

   localparam int ERR_OVF = 0;
   localparam int ERR_UNF = 1;
   localparam int ERR_SEQ = 2;
endpackage

// File: rtl/stack_mem_unit_if.sv
// Bundle between the MEM-stage control/operand sources and the stack unit, plus
// the write-back, CCR and fetch-PC return paths.
interface stack_mem_unit_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16
);
   logic                  op_valid;
   logic [6:0]            mem_ctrl;
   logic [5:0]            wb_ctrl;
   logic [2:0]            rdst_in;
   logic [ADDR_W-1:0]     ea;
   logic [DATA_W-1:0]     reg_data;
   logic [2:0]            flags_in;
   logic [2*DATA_W-1:0]   pc_int;
   logic [2*DATA_W-1:0]   pc_next;
   logic                  wb_valid;
   logic [DATA_W-1:0]     wb_data;
   logic [2:0]            wb_rdst;
   logic                  flags_valid;
   logic [2:0]            flags_out;
   logic                  pc_valid;
   logic [2*DATA_W-1:0]   pc_out;
   logic [ADDR_W-1:0]     sp;
   logic [2:0]            err;

   modport master (
      output op_valid, mem_ctrl, wb_ctrl, rdst_in, ea, reg_data, flags_in, pc_int, pc_next,
      input  wb_valid, wb_data, wb_rdst, flags_valid, flags_out, pc_valid, pc_out, sp, err
   );

   modport slave (
      input  op_valid, mem_ctrl, wb_ctrl, rdst_in, ea, reg_data, flags_in, pc_int, pc_next,
      output wb_valid, wb_data, wb_rdst, flags_valid, flags_out, pc_valid, pc_out, sp, err
   );
endinterface

// File: rtl/stack_mem_unit_sync_ram.sv
// Single-port data RAM: read-first, one-cycle registered read, contents never reset.
module sync_ram #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (re) rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
   end
endmodule

// File: rtl/stack_mem_unit.sv
// Memory-stage executor: stack pointer, data RAM access, one-cycle read response
// and the two-word PC reassembly for RET/RETI.
module stack_mem_unit
   import stack_mem_pkg::*;
#(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   stack_mem_unit_if.slave bus
);
   localparam logic [ADDR_W-1:0] SP_RESET = '1;

   logic [ADDR_W-1:0] sp_q, sp_d, ram_addr;
   logic              acc, rd, wr, conflict, is_push, is_pop, ovf, unf, ram_we, ram_re;
   addr_sel_e         asel;
   data_sel_e         dsel;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;
   logic              pend_q, pend_flags_q, pend_regwr_q;
   logic [1:0]        pend_pop_q;
   logic [2:0]        pend_rdst_q;
   logic              hi_seen_q, hi_seen_d;
   logic [DATA_W-1:0] pc_hi_q, pc_hi_d;
   logic [2:0]        err_q, err_d;
   logic              rsp_hi, rsp_lo, wb_v, fl_v, pc_v;
   logic              unused_wb_sel;

   // wb_sel is consumed by the write-back mux, not here
   assign unused_wb_sel = bus.wb_ctrl[WB_SEL];

   always_comb begin
      acc      = bus.op_valid & rst_n;
      rd       = acc & bus.mem_ctrl[MEM_RD];
      wr       = acc & bus.mem_ctrl[MEM_WR];
      asel     = addr_sel_e'(bus.mem_ctrl[MEM_ASEL_HI:MEM_ASEL_LO]);
      dsel     = data_sel_e'(bus.mem_ctrl[MEM_DSEL_HI:MEM_DSEL_LO]);
      conflict = rd & wr;
      is_push  = wr & ~rd & (asel == ADDR_SEL_PUSH);
      is_pop   = rd & ~wr & (asel == ADDR_SEL_POP);
      ovf      = is_push & (sp_q == '0);
      unf      = is_pop & (sp_q == SP_RESET);
      ram_we   = wr & ~rd & ~ovf;
      ram_re   = rd & ~wr & ~unf;

      case (asel)
         ADDR_SEL_POP:  ram_addr = sp_q + ADDR_W'(1);
         ADDR_SEL_PUSH: ram_addr = sp_q;
         default:       ram_addr = bus.ea;
      endcase

      case (dsel)
         DATA_SEL_FLAGS:  ram_wdata = DATA_W'(bus.flags_in);
         DATA_SEL_PCI_LO: ram_wdata = bus.pc_int[DATA_W-1:0];
         DATA_SEL_PCI_HI: ram_wdata = bus.pc_int[2*DATA_W-1:DATA_W];
         DATA_SEL_PCN_LO: ram_wdata = bus.pc_next[DATA_W-1:0];
         DATA_SEL_PCN_HI: ram_wdata = bus.pc_next[2*DATA_W-1:DATA_W];
         default:         ram_wdata = bus.reg_data;
      endcase

      sp_d = sp_q;
      if (bus.wb_ctrl[WB_SP_WR]) begin
         if (is_push && !ovf)     sp_d = sp_q - ADDR_W'(1);
         else if (is_pop && !unf) sp_d = sp_q + ADDR_W'(1);
      end
   end

   sync_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Response side: the RAM word arrives one cycle after accept with its tagged controls
   always_comb begin
      rsp_hi    = pend_q & (pend_pop_q == POP_HI);
      rsp_lo    = pend_q & (pend_pop_q == POP_LO);
      hi_seen_d = hi_seen_q;
      pc_hi_d   = pc_hi_q;
      if (rsp_hi) begin
         hi_seen_d = 1'b1;
         pc_hi_d   = ram_rdata;
      end else if (rsp_lo) begin
         hi_seen_d = 1'b0;
      end

      err_d          = err_q;
      err_d[ERR_OVF] = err_q[ERR_OVF] | ovf;
      err_d[ERR_UNF] = err_q[ERR_UNF] | unf;
      err_d[ERR_SEQ] = err_q[ERR_SEQ] | conflict | (rsp_lo & ~hi_seen_q);

      wb_v = pend_q & pend_regwr_q & (pend_pop_q != POP_LO);
      fl_v = pend_q & pend_flags_q;
      pc_v = rsp_lo & hi_seen_q;

      bus.wb_valid    = wb_v;
      bus.wb_data     = wb_v ? ram_rdata : '0;
      bus.wb_rdst     = wb_v ? pend_rdst_q : '0;
      bus.flags_valid = fl_v;
      bus.flags_out   = fl_v ? ram_rdata[2:0] : '0;
      bus.pc_valid    = pc_v;
      bus.pc_out      = pc_v ? {pc_hi_q, ram_rdata} : '0;
      bus.sp          = sp_q;
      bus.err         = err_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sp_q         <= SP_RESET;
         pend_q       <= 1'b0;
         pend_flags_q <= 1'b0;
         pend_regwr_q <= 1'b0;
         pend_pop_q   <= 2'b00;
         pend_rdst_q  <= 3'b000;
         hi_seen_q    <= 1'b0;
         pc_hi_q      <= '0;
         err_q        <= 3'b000;
      end else begin
         sp_q         <= sp_d;
         pend_q       <= ram_re;
         pend_flags_q <= bus.wb_ctrl[WB_FLAGS];
         pend_regwr_q <= bus.wb_ctrl[WB_REGWRITE];
         pend_pop_q   <= bus.wb_ctrl[WB_POP_HI:WB_POP_LO];
         pend_rdst_q  <= bus.rdst_in;
         hi_seen_q    <= hi_seen_d;
         pc_hi_q      <= pc_hi_d;
         err_q        <= err_d;
      end
   end
endmodule

// File: tb/tb_stack_mem_unit.sv
// Bench for stack_mem_unit: directed scenarios plus a randomized run, every cycle
// compared against a transaction-level model of the stack and data memory.
module tb_stack_mem_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   stack_mem_unit_if bus ();
   stack_mem_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   localparam logic [6:0] MC_NOP   = 7'b0000000;
   localparam logic [6:0] MC_POP   = 7'b1010000;
   localparam logic [6:0] MC_LDD   = 7'b1000000;
   localparam logic [6:0] MC_STD   = 7'b0100000;
   localparam logic [5:0] WC_PUSH  = 6'b100000;
   localparam logic [5:0] WC_POPR  = 6'b101001;
   localparam logic [5:0] WC_POPHI = 6'b100100;
   localparam logic [5:0] WC_POPLO = 6'b100110;
   localparam logic [5:0] WC_POPFL = 6'b110000;

   // model state
   logic [15:0] m_mem [2048];
   bit   [10:0] m_sp;
   bit   [2:0]  m_err;
   bit          m_hi;
   bit   [15:0] m_pchi;
   bit          r_v;
   bit   [5:0]  r_wc;
   bit   [15:0] r_word;
   logic [2:0]  g_fl;
   logic [31:0] g_pci, g_pcn;

   function automatic logic [6:0] mc_push(input logic [2:0] ds);
      return {4'b0111, ds};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_op(input bit rb, input bit v, input logic [6:0] mc, input logic [5:0] wc,
                        input logic [2:0] rdst, input logic [10:0] ea, input logic [15:0] rdat);
      bit          n_v, e_wb, e_fl, e_pc;
      bit   [15:0] word, wdat;
      bit   [10:0] a;
      rst_n        = rb;
      bus.op_valid = v;
      bus.mem_ctrl = mc;
      bus.wb_ctrl  = wc;
      bus.rdst_in  = rdst;
      bus.ea       = ea;
      bus.reg_data = rdat;
      bus.flags_in = g_fl;
      bus.pc_int   = g_pci;
      bus.pc_next  = g_pcn;
      n_v  = 0;
      word = 0;
      if (!rb) begin
         m_sp = 11'h7ff; m_err = 0; m_hi = 0; m_pchi = 0;
      end else begin
         if (r_v && r_wc[2:1] == 2'b10) begin
            m_pchi = r_word; m_hi = 1;
         end else if (r_v && r_wc[2:1] == 2'b11) begin
            if (!m_hi) m_err[2] = 1;
            m_hi = 0;
         end
         if (v) begin
            a = (mc[4:3] == 2'b10) ? m_sp + 11'd1 : (mc[4:3] == 2'b11) ? m_sp : ea;
            case (mc[2:0])
               3'd2:    wdat = {13'b0, g_fl};
               3'd3:    wdat = g_pci[15:0];
               3'd4:    wdat = g_pci[31:16];
               3'd5:    wdat = g_pcn[15:0];
               3'd6:    wdat = g_pcn[31:16];
               default: wdat = rdat;
            endcase
            if (mc[6] && mc[5]) m_err[2] = 1;
            else if (mc[5]) begin
               if (mc[4:3] == 2'b11 && m_sp == 0) m_err[0] = 1;
               else begin
                  m_mem[a] = wdat;
                  if (mc[4:3] == 2'b11 && wc[5]) m_sp--;
               end
            end else if (mc[6]) begin
               if (mc[4:3] == 2'b10 && m_sp == 11'h7ff) m_err[1] = 1;
               else begin
                  n_v  = 1;
                  word = m_mem[a];
                  if (mc[4:3] == 2'b10 && wc[5]) m_sp++;
               end
            end
         end
      end
      r_v    = n_v;
      r_wc   = wc;
      r_word = word;
      @(posedge clk);
      #1;
      e_wb = n_v && wc[0] && (wc[2:1] != 2'b11);
      e_fl = n_v && wc[4];
      e_pc = n_v && (wc[2:1] == 2'b11) && m_hi;
      chk("wb_valid", bus.wb_valid, e_wb);
      chk("wb_data", bus.wb_data, e_wb ? word : 16'h0);
      chk("wb_rdst", bus.wb_rdst, e_wb ? rdst : 3'h0);
      chk("flags_valid", bus.flags_valid, e_fl);
      chk("flags_out", bus.flags_out, e_fl ? word[2:0] : 3'h0);
      chk("pc_valid", bus.pc_valid, e_pc);
      chk("pc_out", bus.pc_out, e_pc ? {m_pchi, word} : 32'h0);
      chk("sp", bus.sp, m_sp);
      chk("err", bus.err, m_err);
   endtask

   task automatic nop();
      do_op(1, 0, MC_NOP, 6'h0, 3'h0, 11'h0, 16'h0);
   endtask

   task automatic rst_cycle();
      do_op(0, 0, MC_NOP, 6'h0, 3'h0, 11'h0, 16'h0);
   endtask

   initial begin
      int r;
      logic [6:0] mc;
      logic [5:0] wc;
      for (int i = 0; i < 2048; i++) m_mem[i] = 16'h0;
      g_fl = 3'b000; g_pci = 32'h0; g_pcn = 32'h0;

      rst_cycle();
      rst_cycle();
      chk("rst_sp", bus.sp, 11'd2047);
      chk("rst_err", bus.err, 3'b000);
      chk("rst_wb_valid", bus.wb_valid, 1'b0);

      // PUSH then POP
      do_op(1, 1, mc_push(3'b000), WC_PUSH, 3'd0, 11'd0, 16'hBEEF);
      chk("t1_sp", bus.sp, 11'd2046);
      do_op(1, 1, MC_POP, WC_POPR, 3'd3, 11'd0, 16'h0);
      chk("t2_wb_valid", bus.wb_valid, 1'b1);
      chk("t2_wb_data", bus.wb_data, 16'hBEEF);
      chk("t2_wb_rdst", bus.wb_rdst, 3'd3);
      chk("t2_sp", bus.sp, 11'd2047);

      // CALL / RET
      g_pcn = 32'h0001_0234;
      do_op(1, 1, mc_push(3'b101), WC_PUSH, 3'd0, 11'd0, 16'h0);
      do_op(1, 1, mc_push(3'b110), WC_PUSH, 3'd0, 11'd0, 16'h0);
      g_pcn = 32'h0;
      do_op(1, 1, MC_POP, WC_POPHI, 3'd0, 11'd0, 16'h0);
      do_op(1, 1, MC_POP, WC_POPLO, 3'd0, 11'd0, 16'h0);
      chk("t3_pc_valid", bus.pc_valid, 1'b1);
      chk("t3_pc_out", bus.pc_out, 32'h0001_0234);
      chk("t3_sp", bus.sp, 11'd2047);
      nop();
      chk("t3_pc_pulse", bus.pc_valid, 1'b0);

      // interrupt / RETI
      g_fl = 3'b101; g_pci = 32'hA5C3_1E0F;
      do_op(1, 1, mc_push(3'b010), WC_PUSH, 3'd0, 11'd0, 16'h0);
      do_op(1, 1, mc_push(3'b011), WC_PUSH, 3'd0, 11'd0, 16'h0);
      do_op(1, 1, mc_push(3'b100), WC_PUSH, 3'd0, 11'd0, 16'h0);
      g_fl = 3'b000; g_pci = 32'h0;
      do_op(1, 1, MC_POP, WC_POPHI, 3'd0, 11'd0, 16'h0);
      do_op(1, 1, MC_POP, WC_POPLO, 3'd0, 11'd0, 16'h0);
      chk("t4_pc_valid", bus.pc_valid, 1'b1);
      chk("t4_pc_out", bus.pc_out, 32'hA5C3_1E0F);
      do_op(1, 1, MC_POP, WC_POPFL, 3'd0, 11'd0, 16'h0);
      chk("t4_flags_valid", bus.flags_valid, 1'b1);
      chk("t4_flags_out", bus.flags_out, 3'b101);

      // underflow
      do_op(1, 1, MC_POP, WC_POPR, 3'd1, 11'd0, 16'h0);
      chk("t5_unf_wb_valid", bus.wb_valid, 1'b0);
      chk("t5_unf_err", bus.err, 3'b010);
      chk("t5_unf_sp", bus.sp, 11'd2047);

      // reset right after a pop accept, with hi_seen pending
      rst_cycle();
      do_op(1, 1, mc_push(3'b000), WC_PUSH, 3'd0, 11'd0, 16'h1111);
      do_op(1, 1, mc_push(3'b000), WC_PUSH, 3'd0, 11'd0, 16'h2222);
      do_op(1, 1, MC_POP, WC_POPHI, 3'd0, 11'd0, 16'h0);
      do_op(1, 1, MC_POP, WC_POPR, 3'd2, 11'd0, 16'h0);
      do_op(0, 1, MC_POP, WC_POPR, 3'd2, 11'd0, 16'h0);
      chk("t6_wb_valid", bus.wb_valid, 1'b0);
      chk("t6_sp", bus.sp, 11'd2047);
      chk("t6_err", bus.err, 3'b000);
      do_op(1, 1, MC_LDD, 6'b000110, 3'd0, 11'd2047, 16'h0);
      chk("t6_pc_valid", bus.pc_valid, 1'b0);
      nop();
      chk("t6_seq_err", bus.err, 3'b100);

      // fill the stack to the bottom, then overflow
      rst_cycle();
      for (int i = 0; i < 2047; i++)
         do_op(1, 1, mc_push(3'b000), WC_PUSH, 3'd0, 11'd0, 16'($urandom()));
      chk("fill_sp", bus.sp, 11'd0);
      do_op(1, 1, MC_STD, 6'b000000, 3'd0, 11'd0, 16'h1234);
      do_op(1, 1, mc_push(3'b000), WC_PUSH, 3'd0, 11'd0, 16'hDEAD);
      chk("t5_ovf_err", bus.err, 3'b001);
      chk("t5_ovf_sp", bus.sp, 11'd0);
      do_op(1, 1, MC_LDD, 6'b000001, 3'd5, 11'd0, 16'h0);
      chk("t5_ovf_nowrite", bus.wb_data, 16'h1234);

      // randomized traffic
      rst_cycle();
      for (int i = 0; i < 3000; i++) begin
         g_fl  = 3'($urandom());
         g_pci = $urandom();
         g_pcn = $urandom();
         r = int'($urandom_range(0, 99));
         if (r < 8) begin
            do_op(1, 1, 7'($urandom()), 6'($urandom()), 3'($urandom()), 11'($urandom()), 16'($urandom()));
         end else if (r < 10) begin
            do_op(0, 1, 7'($urandom()), 6'($urandom()), 3'($urandom()), 11'($urandom()), 16'($urandom()));
         end else if (r < 20) begin
            do_op(1, 0, 7'($urandom()), 6'($urandom()), 3'($urandom()), 11'($urandom()), 16'($urandom()));
         end else if (r < 40) begin
            do_op(1, 1, mc_push(3'($urandom())), WC_PUSH, 3'd0, 11'($urandom()), 16'($urandom()));
         end else if (r < 60) begin
            wc = WC_POPR;
            wc[4] = 1'($urandom());
            do_op(1, 1, MC_POP, wc, 3'($urandom()), 11'($urandom()), 16'($urandom()));
         end else if (r < 70) begin
            do_op(1, 1, MC_POP, WC_POPHI, 3'($urandom()), 11'($urandom()), 16'($urandom()));
         end else if (r < 80) begin
            do_op(1, 1, MC_POP, WC_POPLO, 3'($urandom()), 11'($urandom()), 16'($urandom()));
         end else if (r < 90) begin
            mc = MC_LDD;
            mc[3] = 1'($urandom());
            do_op(1, 1, mc, 6'b000001, 3'($urandom()), 11'($urandom()), 16'($urandom()));
         end else begin
            mc = MC_STD;
            mc[2:0] = 3'($urandom());
            do_op(1, 1, mc, 6'b000000, 3'd0, 11'($urandom()), 16'($urandom()));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
